// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder assembled from two half-adder stages and an OR.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  assign ha1_s = x ^ y;
  assign ha1_c = x & y;
  assign s     = ha1_s ^ cin;
  assign ha2_c = ha1_s & cin;
  assign cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per enabled cycle, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | adding one bit per enabled cycle, WIDTH cycles
// DONE  | result held on outputs until consumed
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               cy;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               bit_s;
  logic               bit_c;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q;
`endif

  fa_bit u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (cy),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign sum_next = {bit_s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      cy          <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= a;
            b_sh       <= b;
            sum_sh     <= '0;
            cy         <= 1'b0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          cy     <= bit_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
            state       <= DONE;
            out_valid_q <= 1'b1;
            sum_q       <= sum_next;
            carry_q     <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= (a_sh[0] == b_sh[0]) & (bit_s != a_sh[0]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..16).
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  clock enable; low freezes all state.
REQ-005 SHALL have port in_valid  input  1  operands a/b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  A+B modulo 2^WIDTH.
REQ-012 SHALL have port carry  output  1  unsigned carry-out of A+B.
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow (see Configuration).

Function
REQ-014 SHALL be an FSM with states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 SHALL assert in_ready only in IDLE; handshake = in_valid & in_ready & ena.
REQ-016 On handshake SHALL latch a, b into shift registers, clear carry flop, clear bit counter, enter SHIFT.
REQ-017 In SHIFT SHALL, per enabled cycle, add LSBs of A/B plus carry flop via one full-adder bit cell, shift result bit into sum register MSB-first-from-top (LSB-first order), update carry flop, increment counter.
REQ-018 SHALL leave SHIFT after exactly WIDTH enabled cycles and enter DONE; out_valid asserted the cycle after the last SHIFT cycle (handshake-to-out_valid latency WIDTH+1 enabled cycles).
REQ-019 In DONE SHALL hold out_valid, sum, carry, ovf stable until out_valid & out_ready & ena, then return to IDLE.
REQ-020 SHALL NOT accept new operands in the cycle the result is consumed; in_ready rises the following cycle.
REQ-021 SHALL ignore a, b, in_valid outside IDLE; out_ready outside DONE has no effect.
REQ-022 With ena low SHALL hold state, counter, registers, and outputs unchanged.
REQ-023 sum/carry/ovf SHALL be registered; combinational paths from inputs to outputs are forbidden except none.
REQ-024 Counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap during operation.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, sum=0, carry=0, ovf=0, counter=0.
REQ-026 Reset mid-SHIFT or mid-DONE SHALL abort the operation; no result emitted after release.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: ovf = (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB]), latched at DONE entry.
REQ-028 Macro SERIAL_ADDER_OVF_EN undefined: ovf port SHALL be tied 0 and no overflow logic synthesized.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and WIDTH default constant.
REQ-030 Per-bit addition SHALL be sub-module fa_bit (inputs x, y, cin; outputs s, cout), built from two half-adder stages plus OR.

Verification
REQ-031 WIDTH=8, a=0x00, b=0x00 -> out_valid 9 cycles after handshake, sum=0x00, carry=0, ovf=0.
REQ-032 a=0xFF, b=0x01 -> sum=0x00, carry=1, ovf=0; a=0x2D, b=0x17 -> sum=0x44, carry=0.
REQ-033 SERIAL_ADDER_OVF_EN defined, a=0x7F, b=0x01 -> sum=0x80, carry=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, carry=1, ovf=1; undefined -> ovf=0 both.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid/sum stable, in_ready=0; out_ready high -> IDLE, in_ready=1 next cycle.
REQ-035 ena toggled low 3 cycles mid-SHIFT -> latency extends by 3, result unchanged; rst_n pulsed low mid-SHIFT -> out_valid=0, in_ready=1, no result emitted.
